pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC/address width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC after reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100: PC target on trap.
REQ-004 SHALL have parameter BUF_DEPTH, default 2: fetch buffer entries, power of 2, range 2..8.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port jump, input, 1: redirect the PC to pc_imm.
REQ-008 SHALL have port pc_imm, input, XLEN: jump target.
REQ-009 SHALL have port trap, input, 1: redirect the PC to TRAP_VECTOR.
REQ-010 SHALL have port imem_req, output, 1: fetch request to instruction memory.
REQ-011 SHALL have port imem_addr, output, XLEN: fetch address.
REQ-012 SHALL have port imem_ack, input, 1: memory response valid this cycle.
REQ-013 SHALL have port imem_rdata, input, 32: fetched instruction, valid with imem_ack.
REQ-014 SHALL have port instr_valid, output, 1: buffer head valid.
REQ-015 SHALL have port instr_ready, input, 1: consumer accepts the head.
REQ-016 SHALL have port instr, output, 32: head instruction.
REQ-017 SHALL have port instr_pc, output, XLEN: PC of the head instruction.
REQ-018 SHALL have port misalign, output, 1: one-cycle misaligned-target pulse.
REQ-019 SHALL have port bad_addr, output, XLEN: last misaligned target.

Function
REQ-020 SHALL keep fetch_pc, the address of the next request, and drive imem_addr = fetch_pc while imem_req is high.
REQ-021 SHALL use FSM states RUN, WAIT and DISCARD; at most one memory request SHALL be outstanding.
REQ-022 RUN SHALL assert imem_req only when (occupancy + 1) <= BUF_DEPTH; on issue SHALL go to WAIT.
REQ-023 WAIT SHALL hold imem_req and imem_addr stable until imem_ack; on ack SHALL push {fetch_pc, imem_rdata}, SHALL set fetch_pc += 4 (modulo 2^XLEN) and SHALL return to RUN.
REQ-024 Ack-to-instr_valid latency SHALL be 1 cycle when the buffer is empty.
REQ-025 A pop SHALL occur when instr_valid && instr_ready; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-026 Redirect priority SHALL be reset > trap > jump; a redirect SHALL load fetch_pc with the target and SHALL clear the buffer in the same edge, ignoring any same-cycle pop.
REQ-027 A redirect in WAIT without imem_ack SHALL go to DISCARD; DISCARD SHALL drop the next ack's data and then go to RUN.
REQ-028 A redirect coinciding with imem_ack SHALL drop that data and go directly to RUN.
REQ-029 A redirect in DISCARD SHALL update fetch_pc again and SHALL remain in DISCARD.
REQ-030 instr_valid SHALL be 0 in the cycle following any redirect.
REQ-031 instr_valid SHALL never drop without a pop or a redirect, and instr/instr_pc SHALL be stable while instr_valid && !instr_ready.

Reset
REQ-032 On reset SHALL set fetch_pc = RESET_VECTOR, state = RUN, occupancy = 0, imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0, misalign = 0, bad_addr = 0.
REQ-033 A request outstanding at reset SHALL be abandoned; an imem_ack in the first cycle after reset SHALL be ignored.
REQ-034 The first imem_req SHALL assert in the first cycle with reset low.

Configuration
REQ-035 SHALL honour macro PC_MISALIGN_TRAP_EN.
REQ-036 With PC_MISALIGN_TRAP_EN defined: a jump with pc_imm[1:0] != 0 SHALL redirect to TRAP_VECTOR instead, SHALL pulse misalign for one cycle and SHALL latch pc_imm into bad_addr.
REQ-037 With PC_MISALIGN_TRAP_EN undefined: a jump target SHALL have bits [1:0] forced to 0, and misalign and bad_addr SHALL be tied to 0.

Verification
REQ-038 Reset, then constant instr_ready=1 and ack one cycle after req -> imem_addr sequence 0,4,8,12; instr_pc follows with matching rdata.
REQ-039 instr_ready=0 with BUF_DEPTH=2 -> exactly 2 entries buffered, imem_req stays low, head held stable; one pop -> one new request.
REQ-040 jump=1, pc_imm=32'h40 while a request is outstanding -> DISCARD; late ack data is not delivered; next imem_addr = 32'h40; first instr_pc = 32'h40.
REQ-041 trap=1 and jump=1 in the same cycle -> imem_addr = 32'h100; buffer empty next cycle.
REQ-042 jump to 32'h42: with PC_MISALIGN_TRAP_EN -> misalign pulse, bad_addr = 32'h42, fetch from 32'h100; without it -> fetch from 32'h40.
REQ-043 reset asserted mid-WAIT with ack in the following cycle -> ack ignored, instr_valid = 0, first post-reset imem_addr = RESET_VECTOR.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: one outstanding instruction-memory request feeding a small fetch buffer.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned jump targets into traps.
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h0000_0100,
    parameter int              BUF_DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            jump,
    input  logic [XLEN-1:0] pc_imm,
    input  logic            trap,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            misalign,
    output logic [XLEN-1:0] bad_addr
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {RUN, WAIT, DISCARD} state_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   fetch_pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [XLEN-1:0]   fifo_pc    [BUF_DEPTH];
    logic [31:0]       fifo_instr [BUF_DEPTH];

    logic              redirect;
    logic              jump_misaligned;
    logic [XLEN-1:0]   target;
    logic              push, pop;

    assign redirect = trap | jump;

`ifdef PC_MISALIGN_TRAP_EN
    assign jump_misaligned = jump && !trap && (pc_imm[1:0] != 2'b00);
    assign target          = (trap || jump_misaligned) ? TRAP_VECTOR : pc_imm;
`else
    assign jump_misaligned = 1'b0;
    assign target          = trap ? TRAP_VECTOR : (pc_imm & ~XLEN'(3));
`endif

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        push       = 1'b0;
        case (state)
            RUN: begin
                // A request issued alongside a redirect would fetch a stale address.
                if (!reset && !redirect && (count < CNT_W'(BUF_DEPTH))) begin
                    imem_req   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                imem_req = !reset;
                if (imem_ack) begin
                    state_next = RUN;
                    push       = !redirect;
                end else if (redirect) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_ack) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    assign pop         = instr_valid && instr_ready && !redirect;
    assign instr_valid = (count != '0);
    assign imem_addr   = fetch_pc;
    assign instr       = instr_valid ? fifo_instr[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : '0;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= RESET_VECTOR;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state <= state_next;
            if (redirect) begin
                fetch_pc <= target;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: buffer storage is not reset; instr/instr_pc are masked by instr_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= fetch_pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign <= 1'b0;
            bad_addr <= '0;
        end else begin
            misalign <= jump_misaligned;
            if (jump_misaligned) bad_addr <= pc_imm;
        end
    end
`else
    assign misalign = jump_misaligned;
    assign bad_addr = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, back-pressure, redirects, reset mid-request.
// Memory answers one cycle after a request while mem_auto is set; otherwise acks are driven by hand.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        jump;
    logic [31:0] pc_imm;
    logic        trap;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign;
    logic [31:0] bad_addr;

    int vectors = 0;
    int miscompares = 0;
    bit mem_auto = 1'b0;

    pc_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .jump        (jump),
        .pc_imm      (pc_imm),
        .trap        (trap),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .misalign    (misalign),
        .bad_addr    (bad_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; the auto memory acks in the cycle after it first sees a request.
    task automatic tick();
        bit          want;
        logic [31:0] a;
        want = mem_auto && imem_req && !imem_ack;
        a    = imem_addr;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            imem_ack   = want;
            imem_rdata = want ? rd(a) : 32'h0;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; jump = 1'b0; trap = 1'b0; pc_imm = '0;
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
        tick(); tick();
        check("rst_valid",    {31'b0, instr_valid}, 32'd0);
        check("rst_req",      {31'b0, imem_req},    32'd0);
        check("rst_instr",    instr,                32'd0);
        check("rst_instr_pc", instr_pc,             32'd0);
        check("rst_misalign", {31'b0, misalign},    32'd0);
        check("rst_bad_addr", bad_addr,             32'd0);

        // Sequential fetch 0,4,8,12 with a ready consumer.
        mem_auto = 1'b1;
        reset = 1'b0; #1;
        for (int k = 0; k < 4; k++) begin
            check("seq_req",  {31'b0, imem_req}, 32'd1);
            check("seq_addr", imem_addr, 32'(4 * k));
            tick(); tick();
            check("seq_valid", {31'b0, instr_valid}, 32'd1);
            check("seq_pc",    instr_pc, 32'(4 * k));
            check("seq_instr", instr,    rd(32'(4 * k)));
        end

        // Back-pressure: buffer fills to two entries and the head holds.
        instr_ready = 1'b0; #1;
        tick(); tick();
        check("bp_req_low", {31'b0, imem_req}, 32'd0);
        check("bp_head_pc", instr_pc, 32'd12);
        tick(); tick(); tick();
        check("bp_hold_req",   {31'b0, imem_req},    32'd0);
        check("bp_hold_valid", {31'b0, instr_valid}, 32'd1);
        check("bp_hold_pc",    instr_pc, 32'd12);
        check("bp_hold_instr", instr,    rd(32'd12));
        instr_ready = 1'b1; #1;
        tick();
        instr_ready = 1'b0; #1;
        check("pop_head_pc", instr_pc, 32'd16);
        check("pop_req",     {31'b0, imem_req}, 32'd1);
        check("pop_addr",    imem_addr, 32'd20);
        tick(); tick();
        check("refill_req_low", {31'b0, imem_req}, 32'd0);

        // Jump while a request is outstanding: late data is dropped.
        instr_ready = 1'b1; #1;
        tick();
        instr_ready = 1'b0;
        mem_auto = 1'b0; #1;
        check("out_addr", imem_addr, 32'd24);
        tick();
        check("wait_req", {31'b0, imem_req}, 32'd1);
        jump = 1'b1; pc_imm = 32'h40; #1;
        tick();
        jump = 1'b0; #1;
        check("jmp_valid_clr",  {31'b0, instr_valid}, 32'd0);
        check("discard_req",    {31'b0, imem_req},    32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; #1;
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        mem_auto = 1'b1; #1;
        check("late_valid", {31'b0, instr_valid}, 32'd0);
        check("jmp_req",    {31'b0, imem_req},    32'd1);
        check("jmp_addr",   imem_addr, 32'h40);
        tick(); tick();
        check("jmp_valid", {31'b0, instr_valid}, 32'd1);
        check("jmp_pc",    instr_pc, 32'h40);
        check("jmp_instr", instr,    rd(32'h40));

        // Trap beats jump and clears the buffer.
        trap = 1'b1; jump = 1'b1; pc_imm = 32'h80; #1;
        tick();
        trap = 1'b0; jump = 1'b0; instr_ready = 1'b1; #1;
        check("trap_valid_clr", {31'b0, instr_valid}, 32'd0);
        check("trap_addr",      imem_addr, 32'h100);
        tick(); tick();
        check("trap_pc", instr_pc, 32'h100);

        // Misaligned jump target.
        jump = 1'b1; pc_imm = 32'h42; #1;
        tick();
        jump = 1'b0; #1;
        check("mis_valid_clr", {31'b0, instr_valid}, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_pulse",    {31'b0, misalign}, 32'd1);
        check("mis_bad_addr", bad_addr,  32'h42);
        check("mis_addr",     imem_addr, 32'h100);
        tick();
        check("mis_pulse_end", {31'b0, misalign}, 32'd0);
`else
        check("mis_pulse",    {31'b0, misalign}, 32'd0);
        check("mis_bad_addr", bad_addr,  32'h0);
        check("mis_addr",     imem_addr, 32'h40);
        tick();
`endif

        // Reset while waiting; the ack right after reset is ignored.
        mem_auto = 1'b0; #1;
        tick();
        check("pre_rst_req", {31'b0, imem_req}, 32'd1);
        reset = 1'b1; #1;
        check("rst_req_gate", {31'b0, imem_req}, 32'd0);
        tick();
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD1_BAD1; #1;
        check("post_rst_req",  {31'b0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        mem_auto = 1'b1; #1;
        check("stale_ack_valid", {31'b0, instr_valid}, 32'd0);
        check("stale_ack_addr",  imem_addr, 32'h0);
        tick(); tick();
        check("post_rst_valid", {31'b0, instr_valid}, 32'd1);
        check("post_rst_pc",    instr_pc, 32'h0);
        check("post_rst_instr", instr,    rd(32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
